pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the write-enable (xxW) and synchronous-flush (xxRST) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable.
- Resolves data-memory stalls, instruction-fetch misses, load-use hazards, taken branches and the halt drain.
- Sits beside the datapath; is the only source of pipeline register enables and flushes.

Parameters:
- REGBITS, 5, width of register-select fields.
- CNT_W, 32, width of performance counters (used only with PIPE_PERF_EN).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch for current PC complete this cycle.
- dhit  in  1  data-memory access in MEM complete this cycle.
- memREN  in  1  MEM-stage instruction reads data memory.
- memWEN  in  1  MEM-stage instruction writes data memory.
- exMemRead  in  1  EX-stage instruction is a load.
- exWsel  in  REGBITS  destination register of EX-stage instruction.
- idRs  in  REGBITS  ID-stage source register rs.
- idRt  in  REGBITS  ID-stage source register rt.
- branchTaken  in  1  MEM-stage branch/jump resolved taken.
- memHalt  in  1  halt instruction in MEM.
- pcW  out  1  PC write enable.
- ifidW, idexW, exmemW, memwbW  out  1 each  pipeline register enables.
- ifidRST, idexRST, exmemRST, memwbRST  out  1 each  bubble insert.
  - Honoured only when the matching W is 1.
- halt  out  1  processor halted, sticky.

Behaviour:
- Reset state: RUN.
  - Registered outputs reset to 0: halt, counters.
- Decode outputs are combinational from state and inputs.
- States:
  - RUN: normal operation.
  - DRAIN: halt in WB, one cycle.
  - HALTED: terminal.
- RUN priority evaluation, highest first; default is all W=1, all RST=0, pcW=1.
  1. dstall = (memREN|memWEN) & ~dhit:
     - pcW, ifidW, idexW, exmemW = 0.
     - memwbW=1, memwbRST=1 (bubble into WB).
  2. memHalt (no dstall):
     - pcW=0.
     - ifidW/idexW/exmemW=1 with RST=1 (kill younger instructions).
     - memwbW=1, memwbRST=0 (halt retires).
     - Next state DRAIN.
  3. branchTaken:
     - pcW=1 (target loads).
     - ifidRST, idexRST, exmemRST = 1 (W=1).
     - memwbW=1, memwbRST=0.
     - Overrides load-use and ihit=0.
  4. loaduse = exMemRead & (exWsel != 0) & (exWsel==idRs | exWsel==idRt):
     - pcW=0, ifidW=0.
     - idexW=1, idexRST=1.
     - exmemW, memwbW = 1.
  5. ~ihit:
     - pcW=0.
     - ifidW=1, ifidRST=1.
     - Remaining stages advance.
  6. Otherwise: free run.
- Simultaneous events:
  - loaduse & ~ihit: loaduse wins (IF/ID held, not flushed).
  - dstall masks every other event; events re-evaluate once dhit arrives.
- DRAIN:
  - All xxW=1 with xxRST=1; pcW=0.
  - Next state HALTED.
- HALTED:
  - pcW and all W=0; halt=1.
  - Remains until nRST. Inputs ignored.
- Reset mid-stall or mid-drain: state returns to RUN immediately (asynchronous).

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined:
  - Adds outputs stallCycles, flushCount, each CNT_W.
  - stallCycles increments each RUN cycle with dstall, loaduse or ~ihit in effect.
  - flushCount increments each cycle branchTaken is acted on.
  - Both saturate at all-ones, freeze in HALTED, reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- dstall:
  - Stimulus: memREN=1, dhit=0 for 3 cycles, then dhit=1.
  - Response: pcW=0, memwbW=1, memwbRST=1 for 3 cycles; all W=1, RST=0 on the dhit cycle.
- Load-use:
  - Stimulus: exMemRead=1, exWsel=5, idRt=5.
  - Response: pcW=0, ifidW=0, idexRST=1, exmemW=1.
  - Repeat with exWsel=0: free run.
- Branch vs load-use/miss:
  - Stimulus: branchTaken=1 with loaduse true and ihit=0.
  - Response: pcW=1, ifid/idex/exmemRST=1, memwbRST=0.
- Halt:
  - Stimulus: memHalt=1 in RUN.
  - Response: next cycle DRAIN (all RST=1); following cycle halt=1, all W=0; halt stays 1 for 10 cycles regardless of inputs.
- Halt under dstall:
  - Stimulus: memHalt=1, memWEN=1, dhit=0 for 2 cycles.
  - Response: no state change until dhit=1, then DRAIN.
- Reset:
  - Stimulus: nRST low mid-dstall and in HALTED.
  - Response: halt=0, state RUN. With PIPE_PERF_EN, counters read 0; stallCycles=3 after the dstall scenario.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: drives PC enable plus
// pipeline register write-enables and flushes. Optional counters: PIPE_PERF_EN.
module pipeline_ctrl #(
  parameter int REGBITS = 5,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               memREN,
  input  logic               memWEN,
  input  logic               exMemRead,
  input  logic [REGBITS-1:0] exWsel,
  input  logic [REGBITS-1:0] idRs,
  input  logic [REGBITS-1:0] idRt,
  input  logic               branchTaken,
  input  logic               memHalt,
  output logic               pcW,
  output logic               ifidW,
  output logic               idexW,
  output logic               exmemW,
  output logic               memwbW,
  output logic               ifidRST,
  output logic               idexRST,
  output logic               exmemRST,
  output logic               memwbRST,
  output logic               halt
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stallCycles,
  output logic [CNT_W-1:0]   flushCount
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state_q, state_d;
  logic   halt_q, halt_d;
  logic   dstall, loaduse;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be positive");
  end

  assign dstall  = (memREN | memWEN) & ~dhit;
  assign loaduse = exMemRead & (exWsel != '0) & ((exWsel == idRs) | (exWsel == idRt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    case (state_q)
      RUN:     if (!dstall && memHalt) state_d = DRAIN;
      DRAIN: begin
        state_d = HALTED;
        halt_d  = 1'b1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pcW      = 1'b1;
    ifidW    = 1'b1;
    idexW    = 1'b1;
    exmemW   = 1'b1;
    memwbW   = 1'b1;
    ifidRST  = 1'b0;
    idexRST  = 1'b0;
    exmemRST = 1'b0;
    memwbRST = 1'b0;
    case (state_q)
      RUN: begin
        // Priority chain: data stall masks everything, branch beats load-use and misses
        if (dstall) begin
          pcW      = 1'b0;
          ifidW    = 1'b0;
          idexW    = 1'b0;
          exmemW   = 1'b0;
          memwbRST = 1'b1;
        end else if (memHalt) begin
          pcW      = 1'b0;
          ifidRST  = 1'b1;
          idexRST  = 1'b1;
          exmemRST = 1'b1;
        end else if (branchTaken) begin
          ifidRST  = 1'b1;
          idexRST  = 1'b1;
          exmemRST = 1'b1;
        end else if (loaduse) begin
          pcW     = 1'b0;
          ifidW   = 1'b0;
          idexRST = 1'b1;
        end else if (!ihit) begin
          pcW     = 1'b0;
          ifidRST = 1'b1;
        end
      end
      DRAIN: begin
        pcW      = 1'b0;
        ifidRST  = 1'b1;
        idexRST  = 1'b1;
        exmemRST = 1'b1;
        memwbRST = 1'b1;
      end
      default: begin
        pcW    = 1'b0;
        ifidW  = 1'b0;
        idexW  = 1'b0;
        exmemW = 1'b0;
        memwbW = 1'b0;
      end
    endcase
  end

  assign halt = halt_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_evt, flush_evt;

  // Only events that actually won the priority chain are counted
  assign stall_evt = (state_q == RUN) &
                     (dstall | (~memHalt & ~branchTaken & (loaduse | ~ihit)));
  assign flush_evt = (state_q == RUN) & ~dstall & ~memHalt & branchTaken;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed test-plan scenarios then random
// traffic, checked against a behavioural model of the hazard priority rules.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, memREN, memWEN, exMemRead, branchTaken, memHalt;
  logic [4:0] exWsel, idRs, idRt;
  logic       pcW, ifidW, idexW, exmemW, memwbW;
  logic       ifidRST, idexRST, exmemRST, memwbRST, halt;
`ifdef PIPE_PERF_EN
  logic [31:0] stallCycles, flushCount;
`endif

  pipeline_ctrl #(.REGBITS(5), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .memREN(memREN), .memWEN(memWEN), .exMemRead(exMemRead),
    .exWsel(exWsel), .idRs(idRs), .idRt(idRt),
    .branchTaken(branchTaken), .memHalt(memHalt),
    .pcW(pcW), .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW), .memwbW(memwbW),
    .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST), .memwbRST(memwbRST),
    .halt(halt)
`ifdef PIPE_PERF_EN
    , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  ctl;   // {pcW, W[if,id,ex,wb], RST[if,id,ex,wb], halt}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;

  // Model: 0 = running, 1 = draining, 2 = halted
  int          phase = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_fc = 0;

  function automatic logic [9:0] ref_ctl(int ph);
    bit dst, lu;
    dst = (memREN | memWEN) & ~dhit;
    lu  = exMemRead && (exWsel != 0) && (exWsel == idRs || exWsel == idRt);
    if (ph == 2)      return 10'b0_0000_0000_1;
    if (ph == 1)      return 10'b0_1111_1111_0;
    if (dst)          return 10'b0_0001_0001_0;
    if (memHalt)      return 10'b0_1111_1110_0;
    if (branchTaken)  return 10'b1_1111_1110_0;
    if (lu)           return 10'b0_0111_0100_0;
    if (!ihit)        return 10'b0_1111_1000_0;
    return 10'b1_1111_0000_0;
  endfunction

  task automatic drive(input bit rd, input bit wr, input bit dh, input bit ih,
                       input bit emr, input logic [4:0] ews, input logic [4:0] rs,
                       input logic [4:0] rt, input bit br, input bit mh,
                       input bit rst_n, input string tag);
    exp_t e;
    bit   dst, lu;
    @(posedge CLK);
    #1;
    memREN = rd; memWEN = wr; dhit = dh; ihit = ih; exMemRead = emr;
    exWsel = ews; idRs = rs; idRt = rt; branchTaken = br; memHalt = mh;
    nRST = rst_n;
    if (!rst_n) begin
      phase = 0; m_sc = 0; m_fc = 0;
    end
    e.ctl = ref_ctl(phase);
    e.sc  = m_sc;
    e.fc  = m_fc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (rst_n) begin
      dst = rd | wr ? ~dh : 1'b0;
      lu  = emr && (ews != 0) && (ews == rs || ews == rt);
      if (phase == 0) begin
        if (dst || (!mh && !br && (lu || !ih))) m_sc = (m_sc == 32'hFFFF_FFFF) ? m_sc : m_sc + 1;
        if (!dst && !mh && br)                  m_fc = (m_fc == 32'hFFFF_FFFF) ? m_fc : m_fc + 1;
        if (!dst && mh) phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end
    end
  endtask

  task automatic idle(input string tag);
    drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, tag);
  endtask

  task automatic rnd_cycle();
    bit rst_n;
    rst_n = ($urandom_range(0, 99) != 0);
    drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, rst_n, "random");
  endtask

  always @(negedge CLK) begin
    logic [9:0] act;
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halt};
      checks++;
      if (act !== e.ctl)
        $display("FAIL %s ctl: got %b expected %b (pcW,W[4],RST[4],halt)", t, act, e.ctl);
      else passes++;
`ifdef PIPE_PERF_EN
      checks++;
      if (stallCycles !== e.sc) $display("FAIL %s stallCycles: got %0d expected %0d", t, stallCycles, e.sc);
      else passes++;
      checks++;
      if (flushCount !== e.fc) $display("FAIL %s flushCount: got %0d expected %0d", t, flushCount, e.fc);
      else passes++;
`endif
    end
  end

  initial begin
    nRST = 1'b0; ihit = 1; dhit = 1; memREN = 0; memWEN = 0; exMemRead = 0;
    exWsel = 0; idRs = 0; idRt = 0; branchTaken = 0; memHalt = 0;
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset");
    idle("reset_release");
    // dstall for three cycles, then dhit completes the access
    repeat (3) drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "dstall");
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "dstall_hit");
    idle("after_dstall");
    // load-use on rt, then same with $zero destination
    drive(0, 0, 1, 1, 1, 5'd5, 5'd2, 5'd5, 0, 0, 1, "loaduse_rt");
    drive(0, 0, 1, 1, 1, 5'd7, 5'd7, 5'd1, 0, 0, 1, "loaduse_rs");
    drive(0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 1, "loaduse_r0");
    drive(0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, "loaduse_vs_miss");
    drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, "imiss");
    drive(0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd5, 1, 0, 1, "branch_override");
    // halt then inputs ignored for ten cycles
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, "halt_mem");
    idle("drain");
    repeat (10) drive(1, 1, 0, 0, 1, 5'd3, 5'd3, 5'd3, 1, 1, 1, "halted");
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset_in_halted");
    idle("after_halt_reset");
    // halt held off by a data stall
    repeat (2) drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, "halt_dstall");
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, "halt_dhit");
    idle("drain2");
    idle("halted2");
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset_halted2");
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "pre_reset_dstall");
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "reset_mid_dstall");
    idle("after_dstall_reset");
    repeat (2000) rnd_cycle();
    idle("final");
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
